// File: rtl/regfile_mips_mp.sv
// ---------------------------------------------------------------------------
// regfile_mips_mp
//   Multi-read-port register file for the MIPS core with write-first bypass,
//   an optional hardwired zero register and a per-register pending
//   scoreboard. Multi-cycle units lock their destination register when they
//   issue, and the lock is released by the writeback to that register.
//
// Ports
//   clk        rising-edge clock
//   arst       asynchronous reset, active high
//   r_en       per-read-port enable
//   r_addr     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   r_data     packed registered read data, port i at [i*DATA_W +: DATA_W]
//   r_pend     per-port registered "source register pending" flag
//   w_en       write enable
//   w_addr     write address
//   w_data     write data
//   lock_en    mark lock_addr pending
//   lock_addr  register to lock
//   pend_cnt   registered number of pending registers
//   dbg_addr   debug read address
//   dbg_data   combinational storage contents at dbg_addr (no bypass)
// ---------------------------------------------------------------------------
module regfile_mips_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_RD-1:0]        r_en,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  output logic [NUM_RD-1:0]        r_pend,
  input  logic                     w_en,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  output logic [ADDR_W:0]          pend_cnt,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pendVec;

  logic              w_wrOk;
  logic              w_lockOk;
  logic [DEPTH-1:0]  w_pendNext;
  logic [ADDR_W:0]   w_pendCount;
  logic [ADDR_W-1:0] w_rdAddr [NUM_RD];

  // Qualified write/lock strobes. Comparing against 1'b1 makes an unknown
  // enable behave as "no update". With the zero register enabled, anything
  // aimed at address 0 is dropped here, so it can neither store, bypass nor
  // lock, and r_mem[0] stays 0 forever.
  always_comb begin
    w_wrOk   = (w_en == 1'b1);
    w_lockOk = (lock_en == 1'b1);
    if (ZERO_REG != 0) begin
      if (w_addr == '0)    w_wrOk   = 1'b0;
      if (lock_addr == '0) w_lockOk = 1'b0;
    end
  end

  // Next-state scoreboard: the writeback clears first, then a lock sets, so
  // a same-edge lock from a newer instruction wins over the clear.
  always_comb begin
    w_pendNext = r_pendVec;
    if (w_wrOk)   w_pendNext[w_addr]    = 1'b0;
    if (w_lockOk) w_pendNext[lock_addr] = 1'b1;
  end

  // Population count of the next-state scoreboard; ADDR_W+1 bits hold the
  // full range 0..DEPTH so it can never wrap.
  always_comb begin
    w_pendCount = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pendCount = w_pendCount + (ADDR_W+1)'(w_pendNext[k]);
    end
  end

  // Unpack the per-port read addresses.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rdAddr[i] = r_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Storage array.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wrOk) begin
      r_mem[w_addr] <= w_data;
    end
  end

  // Scoreboard state and its registered count.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_pendVec <= '0;
      pend_cnt  <= '0;
    end else begin
      r_pendVec <= w_pendNext;
      pend_cnt  <= w_pendCount;
    end
  end

  // Registered read ports with write-first bypass. The pending flag is
  // taken from the next-state scoreboard so a same-edge writeback or lock
  // is already visible to the consumer.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_data <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (r_en[i] == 1'b1) begin
          if (w_wrOk && (w_addr == w_rdAddr[i])) begin
            r_data[i*DATA_W +: DATA_W] <= w_data;
          end else begin
            r_data[i*DATA_W +: DATA_W] <= r_mem[w_rdAddr[i]];
          end
          r_pend[i] <= w_pendNext[w_rdAddr[i]];
        end else begin
          r_data[i*DATA_W +: DATA_W] <= '0;
          r_pend[i]                  <= 1'b0;
        end
      end
    end
  end

  assign dbg_data = r_mem[dbg_addr];

endmodule

// File: tb/tb_regfile_mips_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mips_mp
//   Self-checking bench for regfile_mips_mp. Two instances are exercised:
//   instance A uses the default build (32-bit, 32 regs, 2 ports, zero reg),
//   instance B a small build (16-bit, 8 regs, 3 ports, ordinary reg 0).
//   A behavioural model keeps plain arrays of contents and pending flags;
//   a registered read simply returns the post-edge contents of the model.
// ---------------------------------------------------------------------------
module tb_regfile_mips_mp;

  logic clk;
  logic arst;

  // Instance A signals (default parameters)
  logic [1:0]  aREn;
  logic [9:0]  aRAddr;
  logic [63:0] aRData;
  logic [1:0]  aRPend;
  logic        aWEn;
  logic [4:0]  aWAddr;
  logic [31:0] aWData;
  logic        aLockEn;
  logic [4:0]  aLockAddr;
  logic [5:0]  aPendCnt;
  logic [4:0]  aDbgAddr;
  logic [31:0] aDbgData;

  // Instance B signals (DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0)
  logic [2:0]  bREn;
  logic [8:0]  bRAddr;
  logic [47:0] bRData;
  logic [2:0]  bRPend;
  logic        bWEn;
  logic [2:0]  bWAddr;
  logic [15:0] bWData;
  logic        bLockEn;
  logic [2:0]  bLockAddr;
  logic [3:0]  bPendCnt;
  logic [2:0]  bDbgAddr;
  logic [15:0] bDbgData;

  regfile_mips_mp dutA (
    .clk(clk), .arst(arst),
    .r_en(aREn), .r_addr(aRAddr), .r_data(aRData), .r_pend(aRPend),
    .w_en(aWEn), .w_addr(aWAddr), .w_data(aWData),
    .lock_en(aLockEn), .lock_addr(aLockAddr), .pend_cnt(aPendCnt),
    .dbg_addr(aDbgAddr), .dbg_data(aDbgData)
  );

  regfile_mips_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) dutB (
    .clk(clk), .arst(arst),
    .r_en(bREn), .r_addr(bRAddr), .r_data(bRData), .r_pend(bRPend),
    .w_en(bWEn), .w_addr(bWAddr), .w_data(bWData),
    .lock_en(bLockEn), .lock_addr(bLockAddr), .pend_cnt(bPendCnt),
    .dbg_addr(bDbgAddr), .dbg_data(bDbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus for the next cycle
  bit [2:0]    sREn;
  int          sRAddr [3];
  bit          sWEn;
  int          sWAddr;
  logic [31:0] sWData;
  bit          sLockEn;
  int          sLockAddr;
  int          sDbgAddr;

  // Reference model state per instance and expected outputs
  logic [31:0] mMem  [2][32];
  bit          mPend [2][32];
  logic [31:0] expData [3];
  bit          expPend [3];
  int          expCnt;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic setIdle();
    sREn = '0;
    for (int p = 0; p < 3; p++) sRAddr[p] = 0;
    sWEn = 0; sWAddr = 0; sWData = '0;
    sLockEn = 0; sLockAddr = 0; sDbgAddr = 0;
  endtask

  task automatic modelClear();
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < 32; k++) begin
        mMem[n][k]  = '0;
        mPend[n][k] = 0;
      end
  endtask

  task automatic idleA();
    aREn = '0; aRAddr = '0; aWEn = 0; aWAddr = '0; aWData = '0;
    aLockEn = 0; aLockAddr = '0; aDbgAddr = '0;
  endtask

  task automatic idleB();
    bREn = '0; bRAddr = '0; bWEn = 0; bWAddr = '0; bWData = '0;
    bLockEn = 0; bLockAddr = '0; bDbgAddr = '0;
  endtask

  // Drives one cycle of stimulus into the chosen instance (the other one
  // idles), updates the model by the rules and waits just past the edge.
  task automatic applyStimulus(input int inst);
    int          nrd;
    int          depth;
    bit          zr;
    logic [31:0] wd;
    bit          wOk;
    bit          lOk;
    nrd   = (inst == 0) ? 2 : 3;
    depth = (inst == 0) ? 32 : 8;
    zr    = (inst == 0);
    wd    = (inst == 0) ? sWData : (sWData & 32'h0000FFFF);
    if (inst == 0) begin
      idleB();
      aREn = sREn[1:0];
      for (int p = 0; p < 2; p++) aRAddr[p*5 +: 5] = 5'(sRAddr[p]);
      aWEn = sWEn; aWAddr = 5'(sWAddr); aWData = wd;
      aLockEn = sLockEn; aLockAddr = 5'(sLockAddr); aDbgAddr = 5'(sDbgAddr);
    end else begin
      idleA();
      bREn = sREn;
      for (int p = 0; p < 3; p++) bRAddr[p*3 +: 3] = 3'(sRAddr[p]);
      bWEn = sWEn; bWAddr = 3'(sWAddr); bWData = wd[15:0];
      bLockEn = sLockEn; bLockAddr = 3'(sLockAddr); bDbgAddr = 3'(sDbgAddr);
    end
    wOk = sWEn && !(zr && sWAddr == 0);
    lOk = sLockEn && !(zr && sLockAddr == 0);
    if (wOk) begin
      mMem[inst][sWAddr]  = wd;
      mPend[inst][sWAddr] = 0;
    end
    if (lOk) mPend[inst][sLockAddr] = 1;
    for (int p = 0; p < 3; p++) begin
      expData[p] = '0;
      expPend[p] = 0;
      if (p < nrd && sREn[p]) begin
        expData[p] = mMem[inst][sRAddr[p]];
        expPend[p] = mPend[inst][sRAddr[p]];
      end
    end
    expCnt = 0;
    for (int k = 0; k < depth; k++) expCnt += int'(mPend[inst][k]);
    @(posedge clk);
    #1;
  endtask

  // Compares every output of the chosen instance against the model.
  task automatic checkCycle(input int inst, input string tag);
    if (inst == 0) begin
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("%s_d%0d", tag, p), 64'(aRData[p*32 +: 32]), 64'(expData[p]));
        checkOutput($sformatf("%s_p%0d", tag, p), 64'(aRPend[p]), 64'(expPend[p]));
      end
      checkOutput({tag, "_cnt"}, 64'(aPendCnt), 64'(expCnt));
      checkOutput({tag, "_dbg"}, 64'(aDbgData), 64'(mMem[0][sDbgAddr]));
    end else begin
      for (int p = 0; p < 3; p++) begin
        checkOutput($sformatf("%s_d%0d", tag, p), 64'(bRData[p*16 +: 16]), 64'(expData[p]));
        checkOutput($sformatf("%s_p%0d", tag, p), 64'(bRPend[p]), 64'(expPend[p]));
      end
      checkOutput({tag, "_cnt"}, 64'(bPendCnt), 64'(expCnt));
      checkOutput({tag, "_dbg"}, 64'(bDbgData), 64'(mMem[1][sDbgAddr]));
    end
  endtask

  // Random traffic on one instance; reads are biased toward the write
  // address so the bypass path is hit often.
  task automatic randomRun(input int inst, input int cycles);
    int depth;
    depth = (inst == 0) ? 32 : 8;
    for (int c = 0; c < cycles; c++) begin
      sREn      = 3'($urandom);
      sWEn      = ($urandom_range(0, 1) == 1);
      sWAddr    = $urandom_range(0, depth - 1);
      sWData    = $urandom;
      sLockEn   = ($urandom_range(0, 9) < 3);
      sLockAddr = $urandom_range(0, depth - 1);
      sDbgAddr  = $urandom_range(0, depth - 1);
      for (int p = 0; p < 3; p++)
        sRAddr[p] = ($urandom_range(0, 3) == 0) ? sWAddr : $urandom_range(0, depth - 1);
      applyStimulus(inst);
      checkCycle(inst, $sformatf("rnd%0d", inst));
    end
  endtask

  initial begin
    arst = 1'b1;
    idleA();
    idleB();
    setIdle();
    modelClear();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dataA", 64'(aRData), 64'd0);
    checkOutput("rst_cntA", 64'(aPendCnt), 64'd0);
    checkOutput("rst_dataB", 64'(bRData), 64'd0);
    @(negedge clk);
    arst = 1'b0;

    // Mid-cycle reset with content and a lock present
    setIdle();
    sWEn = 1; sWAddr = 5; sWData = 32'hDEADBEEF;
    sLockEn = 1; sLockAddr = 2; sDbgAddr = 5;
    applyStimulus(0);
    checkCycle(0, "prerst");
    checkOutput("prerst_dbg5", 64'(aDbgData), 64'hDEADBEEF);
    #3;
    arst = 1'b1;
    #1;
    modelClear();
    checkOutput("rst_async_data", 64'(aRData), 64'd0);
    checkOutput("rst_async_cnt", 64'(aPendCnt), 64'd0);
    checkOutput("rst_async_dbg5", 64'(aDbgData), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_dbg5", 64'(aDbgData), 64'd0);
    checkOutput("rst_hold_cnt", 64'(aPendCnt), 64'd0);
    @(negedge clk);
    arst = 1'b0;

    // Write-first bypass; port 1 disabled reads zero
    setIdle();
    sWEn = 1; sWAddr = 7; sWData = 32'h12345678;
    sREn = 3'b001; sRAddr[0] = 7; sRAddr[1] = 7;
    applyStimulus(0);
    checkCycle(0, "byp");
    checkOutput("byp_const0", 64'(aRData[31:0]), 64'h12345678);
    checkOutput("byp_const1", 64'(aRData[63:32]), 64'd0);

    // Zero register on A: write and lock are ignored
    setIdle();
    sWEn = 1; sWAddr = 0; sWData = 32'hFFFFFFFF; sLockEn = 1; sLockAddr = 0;
    sREn = 3'b011;
    applyStimulus(0);
    checkCycle(0, "zr_same");
    checkOutput("zr_const_d", 64'(aRData), 64'd0);
    checkOutput("zr_const_p", 64'(aRPend), 64'd0);
    checkOutput("zr_const_cnt", 64'(aPendCnt), 64'd0);
    setIdle();
    sREn = 3'b011;
    applyStimulus(0);
    checkCycle(0, "zr_next");

    // Scoreboard: lock r3 and r9, then write back r3
    setIdle(); sLockEn = 1; sLockAddr = 3;
    applyStimulus(0); checkCycle(0, "sb_l3");
    setIdle(); sLockEn = 1; sLockAddr = 9; sREn = 3'b001; sRAddr[0] = 3;
    applyStimulus(0); checkCycle(0, "sb_l9");
    checkOutput("sb_cnt2", 64'(aPendCnt), 64'd2);
    checkOutput("sb_p3", 64'(aRPend[0]), 64'd1);
    setIdle(); sWEn = 1; sWAddr = 3; sWData = 32'hA5A5_0003; sREn = 3'b011;
    sRAddr[0] = 3; sRAddr[1] = 9;
    applyStimulus(0); checkCycle(0, "sb_wb3");
    checkOutput("sb_cnt1", 64'(aPendCnt), 64'd1);
    checkOutput("sb_wb_p3", 64'(aRPend[0]), 64'd0);

    // Write and lock collision, then re-lock
    setIdle(); sWEn = 1; sWAddr = 4; sWData = 32'hC0FFEE04;
    sLockEn = 1; sLockAddr = 4; sREn = 3'b001; sRAddr[0] = 4; sDbgAddr = 4;
    applyStimulus(0); checkCycle(0, "col");
    checkOutput("col_cnt", 64'(aPendCnt), 64'd2);
    checkOutput("col_dbg", 64'(aDbgData), 64'hC0FFEE04);
    setIdle(); sLockEn = 1; sLockAddr = 4; sREn = 3'b010; sRAddr[1] = 4;
    applyStimulus(0); checkCycle(0, "relock");
    checkOutput("relock_cnt", 64'(aPendCnt), 64'd2);

    // Instance B: ordinary register 0
    setIdle(); sWEn = 1; sWAddr = 0; sWData = 32'h0000FFFF;
    applyStimulus(1); checkCycle(1, "b_r0w");
    setIdle(); sREn = 3'b111;
    applyStimulus(1); checkCycle(1, "b_r0r");
    checkOutput("b_r0_const", 64'(bRData), 64'hFFFF_FFFF_FFFF);

    // Instance B: fill every register, read all back through 3 ports
    for (int k = 0; k < 8; k++) begin
      setIdle(); sWEn = 1; sWAddr = k; sWData = $urandom;
      applyStimulus(1); checkCycle(1, "b_fill");
    end
    for (int k = 0; k < 3; k++) begin
      setIdle(); sREn = 3'b111;
      for (int p = 0; p < 3; p++) sRAddr[p] = (k * 3 + p) % 8;
      applyStimulus(1); checkCycle(1, "b_read");
    end

    // Instance B: lock r1..r7, then r0 to reach the full count, then re-lock
    for (int k = 1; k < 8; k++) begin
      setIdle(); sLockEn = 1; sLockAddr = k;
      applyStimulus(1); checkCycle(1, "b_lock");
    end
    checkOutput("b_cnt7", 64'(bPendCnt), 64'd7);
    setIdle(); sLockEn = 1; sLockAddr = 0;
    applyStimulus(1);
    checkOutput("b_cnt8", 64'(bPendCnt), 64'd8);
    setIdle(); sLockEn = 1; sLockAddr = 5;
    applyStimulus(1);
    checkOutput("b_cnt8_hold", 64'(bPendCnt), 64'd8);

    // Randomized traffic against the model
    randomRun(0, 200);
    randomRun(1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
